// File: rtl/nes_pkg.sv
// Shared types and constants for the NES controller poll engine.
package nes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } nes_state_e;

  // Button positions in serial shift order
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int NUM_PADS = 2;

endpackage

// File: rtl/nes_pad_poller_if.sv
// Consumer-side control and frame-publication bundle of the pad poller.
interface nes_pad_poller_if;
  logic       enable;
  logic       poll_req;
  logic [7:0] buttons0;
  logic [7:0] buttons1;
  logic [7:0] pressed0;
  logic [7:0] pressed1;
  logic       valid;
  logic       busy;

  modport master (
    output enable, poll_req,
    input  buttons0, buttons1, pressed0, pressed1, valid, busy
  );

  modport slave (
    input  enable, poll_req,
    output buttons0, buttons1, pressed0, pressed1, valid, busy
  );
endinterface

// File: rtl/nes_tick_gen.sv
// Free-running prescaler: one-cycle tick every CLK_DIV clocks, re-phased by clr.
module nes_tick_gen #(
  parameter int CLK_DIV = 300
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/nes_pad_poller.sv
// Scheduled NES pad poll engine: drives latch/pulse strobes, shifts in both pads,
// and publishes button vectors with a one-cycle valid.
module nes_pad_poller
  import nes_pkg::*;
#(
  parameter int CLK_DIV     = 300,
  parameter int POLL_PERIOD = 200000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_PADS-1:0] nes_data,
  output logic                nes_latch,
  output logic                nes_pulse,
  nes_pad_poller_if.slave     bus
);

  localparam int PCW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [PCW-1:0] PERIOD_LAST = PCW'(POLL_PERIOD - 1);

  nes_state_e                     state;
  logic                           half;
  logic [2:0]                     bit_idx;
  logic                           pending;
  logic                           valid_q;
  logic                           busy_q;
  logic [PCW-1:0]                 period_cnt;
  logic [NUM_PADS-1:0]            data_p0;
  logic [NUM_PADS-1:0]            data_p1;
  logic [NUM_PADS-1:0]            sample;
  logic [NUM_PADS-1:0][6:0]       shbuf;
  logic [NUM_PADS-1:0][7:0]       frame;
  logic [NUM_PADS-1:0][7:0]       btn_q;
  logic [NUM_PADS-1:0][7:0]       prs_q;
  logic                           expiry;
  logic                           trigger;
  logic                           go;
  logic                           tick;
  logic                           tick_clr;

  // Stage p0/p1: two-flop synchronizer on the asynchronous pad data lines
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_p0 <= '0;
      data_p1 <= '0;
    end else begin
      data_p0 <= nes_data;
      data_p1 <= data_p0;
    end
  end

  // Pad lines are active-low
  assign sample = ~data_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_cnt <= '0;
    end else if (!bus.enable || period_cnt == PERIOD_LAST) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PCW'(1);
    end
  end

  assign expiry   = bus.enable && (period_cnt == PERIOD_LAST);
  assign trigger  = bus.poll_req || expiry;
  assign go       = trigger || pending;
  assign tick_clr = (state == ST_IDLE) && go;

  nes_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (tick_clr),
    .tick  (tick)
  );

  // The last bit is taken straight from the synchronizer so DONE can publish it
  always_comb begin
    frame = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      frame[p] = {sample[p], shbuf[p]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      half      <= 1'b0;
      bit_idx   <= 3'(BTN_A);
      pending   <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      nes_latch <= 1'b0;
      nes_pulse <= 1'b0;
      shbuf     <= '0;
      btn_q     <= '0;
      prs_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      if (state != ST_IDLE && trigger) begin
        pending <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (go) begin
            state     <= ST_LATCH;
            nes_latch <= 1'b1;
            busy_q    <= 1'b1;
            half      <= 1'b0;
            pending   <= 1'b0;
          end
        end
        ST_LATCH: begin
          if (tick) begin
            if (half) begin
              state     <= ST_READ;
              nes_latch <= 1'b0;
              half      <= 1'b0;
              bit_idx   <= 3'(BTN_A);
            end else begin
              half <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (tick) begin
            if (!half) begin
              if (bit_idx == 3'(BTN_RIGHT)) begin
                state   <= ST_DONE;
                valid_q <= 1'b1;
                for (int p = 0; p < NUM_PADS; p++) begin
                  btn_q[p] <= frame[p];
                  prs_q[p] <= frame[p] & ~btn_q[p];
                end
              end else begin
                for (int p = 0; p < NUM_PADS; p++) begin
                  shbuf[p][bit_idx] <= sample[p];
                end
                half      <= 1'b1;
                nes_pulse <= 1'b1;
              end
            end else begin
              half      <= 1'b0;
              nes_pulse <= 1'b0;
              bit_idx   <= bit_idx + 3'd1;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.buttons0 = btn_q[0];
  assign bus.buttons1 = btn_q[1];
  assign bus.pressed0 = prs_q[0];
  assign bus.pressed1 = prs_q[1];
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_nes_pad_poller.sv
// Directed bench for nes_pad_poller with a behavioural pair of NES pads.
module tb_nes_pad_poller;

  localparam int D = 4;
  localparam int P = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] nes_data;
  logic       nes_latch;
  logic       nes_pulse;

  nes_pad_poller_if bus();

  nes_pad_poller #(
    .CLK_DIV     (D),
    .POLL_PERIOD (P)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .nes_data  (nes_data),
    .nes_latch (nes_latch),
    .nes_pulse (nes_pulse),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  // Pad model: latch loads the parallel buttons, pulse rising edge shifts
  logic [7:0] pad_btn [2];
  logic [7:0] sh [2];
  logic       pulse_d;

  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (nes_latch) sh[p] <= pad_btn[p];
      else if (nes_pulse && !pulse_d) sh[p] <= {1'b0, sh[p][7:1]};
    end
    pulse_d <= nes_pulse;
  end

  assign nes_data = {~sh[1][0], ~sh[0][0]};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_latch(input int t);
    return (t >= 0) && (t < 2 * D);
  endfunction

  function automatic logic exp_pulse(input int t);
    int u;
    if (t < 2 * D || t >= 17 * D) return 1'b0;
    u = t - 2 * D;
    return ((u % (2 * D)) >= D) && ((u / (2 * D)) <= 6);
  endfunction

  // Called at T0; returns with the simulation sitting in the valid cycle
  task automatic watch(output int vt, output int smis);
    vt   = -1;
    smis = 0;
    for (int t = 0; t < 100; t++) begin
      if (nes_latch !== exp_latch(t) || nes_pulse !== exp_pulse(t)) smis++;
      if (bus.valid === 1'b1) begin
        vt = t;
        break;
      end
      step();
    end
  endtask

  typedef struct {
    logic [7:0] p0;
    logic [7:0] p1;
    logic [7:0] eb0;
    logic [7:0] eb1;
    logic [7:0] ep0;
    logic [7:0] ep1;
  } vec_t;

  vec_t vecs [6];

  task automatic poll_vec(input vec_t v, input string tag);
    int vt, smis;
    pad_btn[0]   = v.p0;
    pad_btn[1]   = v.p1;
    bus.poll_req = 1'b1;
    step();
    bus.poll_req = 1'b0;
    chk({tag, "_busy_t0"}, bus.busy, 1);
    watch(vt, smis);
    chk({tag, "_valid_t"}, vt, 17 * D);
    chk({tag, "_strobes"}, smis, 0);
    chk({tag, "_buttons0"}, bus.buttons0, v.eb0);
    chk({tag, "_buttons1"}, bus.buttons1, v.eb1);
    chk({tag, "_pressed0"}, bus.pressed0, v.ep0);
    chk({tag, "_pressed1"}, bus.pressed1, v.ep1);
    step();
    chk({tag, "_idle"}, {bus.busy, bus.valid}, 0);
  endtask

  initial begin
    int rises [$];
    int nvalid, vts[$];
    int vt, smis;
    logic prev;

    vecs[0] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00};
    vecs[1] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{8'h80, 8'h00, 8'h80, 8'h00, 8'h80, 8'h00};
    vecs[3] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'h25, 8'h3C};
    vecs[4] = '{8'hFF, 8'hC3, 8'hFF, 8'hC3, 8'h5A, 8'hC3};
    vecs[5] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h3C};

    pad_btn[0]   = 8'h00;
    pad_btn[1]   = 8'h00;
    bus.enable   = 1'b0;
    bus.poll_req = 1'b0;
    reset        = 1'b1;
    repeat (3) step();
    chk("reset_ctrl", {nes_latch, nes_pulse, bus.valid, bus.busy}, 0);
    chk("reset_vec", {bus.buttons0, bus.buttons1, bus.pressed0, bus.pressed1}, 0);
    reset = 1'b0;
    repeat (3) step();

    foreach (vecs[i]) poll_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset during bit 4 pulse-high phase
    pad_btn[0]   = 8'h5A;
    pad_btn[1]   = 8'h81;
    bus.poll_req = 1'b1;
    step();
    bus.poll_req = 1'b0;
    repeat (45) step();
    chk("rst_mid_pulse_before", nes_pulse, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_strobes", {nes_latch, nes_pulse}, 0);
    chk("rst_mid_state", {bus.busy, bus.valid}, 0);
    chk("rst_mid_vec", {bus.buttons0, bus.buttons1}, 0);
    step();
    step();
    reset  = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (bus.valid === 1'b1 || nes_latch === 1'b1) nvalid++;
    end
    chk("rst_mid_quiet", nvalid, 0);
    poll_vec('{8'h5A, 8'h81, 8'h5A, 8'h81, 8'h5A, 8'h81}, "after_rst");

    // Periodic polling
    repeat (5) step();
    bus.enable = 1'b1;
    prev = nes_latch;
    rises.delete();
    for (int i = 1; i <= 4 * P; i++) begin
      step();
      if (nes_latch && !prev) rises.push_back(i);
      prev = nes_latch;
    end
    chk("period_count", rises.size(), 4);
    if (rises.size() == 4) begin
      chk("period_first", rises[0], P);
      for (int k = 1; k < 4; k++) chk($sformatf("period_gap%0d", k), rises[k] - rises[k-1], P);
    end
    bus.enable = 1'b0;
    rises.delete();
    for (int i = 0; i < 3 * P; i++) begin
      step();
      if (nes_latch && !prev) rises.push_back(i);
      prev = nes_latch;
    end
    chk("disabled_no_poll", rises.size(), 0);

    // Manual request and period expiry on the same IDLE cycle
    bus.enable = 1'b1;
    repeat (P - 1) step();
    bus.poll_req = 1'b1;
    step();
    bus.poll_req = 1'b0;
    chk("coinc_t0", nes_latch, 1);
    watch(vt, smis);
    chk("coinc_valid_t", vt, 17 * D);
    step();
    chk("coinc_busy_drop", bus.busy, 0);
    prev = nes_latch;
    rises.delete();
    for (int t = 70; t < P; t++) begin
      step();
      if (nes_latch && !prev) rises.push_back(t);
      prev = nes_latch;
    end
    chk("coinc_no_second", rises.size(), 0);
    bus.enable = 1'b0;
    repeat (80) step();

    // Three requests during READ coalesce into one extra poll
    pad_btn[0]   = 8'h11;
    pad_btn[1]   = 8'h22;
    bus.poll_req = 1'b1;
    step();
    bus.poll_req = 1'b0;
    prev = 1'b1;
    rises.delete();
    vts.delete();
    for (int t = 0; t <= 200; t++) begin
      if (nes_latch && !prev) rises.push_back(t);
      if (bus.valid === 1'b1) vts.push_back(t);
      prev = nes_latch;
      bus.poll_req = (t == 20 || t == 30 || t == 40);
      step();
    end
    bus.poll_req = 1'b0;
    chk("coal_nvalid", vts.size(), 2);
    chk("coal_nrise", rises.size(), 1);
    if (vts.size() >= 1) chk("coal_valid1_t", vts[0], 17 * D);
    if (rises.size() >= 1) chk("coal_t0b", rises[0], 17 * D + 2);
    if (vts.size() >= 2) chk("coal_valid2_t", vts[1], 2 * (17 * D) + 2);
    chk("coal_buttons", {bus.buttons0, bus.buttons1}, 16'h1122);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nes_pad_poller.md
# nes_pad_poller

Sequencer for the NES controller serial interface: generates the shared latch and pulse strobes, samples two controller data lines in parallel, and publishes debounced-by-frame button vectors. It replaces free-running shift-register readout with a scheduled poll engine that the game/UI logic reads through a one-cycle valid handshake. It sits between the controller port pins and the button-consumer logic.

## Interface
- `CLK_DIV`, default 300: clk cycles per tick (one strobe half-period); legal ≥ 3.
- `POLL_PERIOD`, default 200000: clk cycles between automatic polls; legal > 17*CLK_DIV + 2.
- `clk  in  1  single system clock; all logic on rising edge`
- `reset  in  1  asynchronous, active-high; clears all state`
- `enable  in  1  1 = automatic periodic polling active`
- `poll_req  in  1  one-cycle manual poll request`
- `nes_data  in  2  controller serial data, active-low, asynchronous (bit n = pad n)`
- `nes_latch  out  1  latch strobe to both pads`
- `nes_pulse  out  1  clock strobe to both pads`
- `buttons0, buttons1  out  8  current state of pad 0 / pad 1, 1 = pressed`
- `pressed0, pressed1  out  8  newly pressed buttons this frame (valid with `valid`)`
- `valid  out  1  one-cycle pulse: new frame published`
- `busy  out  1  poll in progress (state ≠ IDLE)`

## Operation
- Bit mapping: index 0..7 = A, B, Select, Start, Up, Down, Left, Right (serial order).
- `nes_data` passes through a 2-flop synchronizer per line; sampled value is inverted (pressed = 1).
- FSM states: IDLE → LATCH → READ → DONE → IDLE.
- IDLE: strobes low. Leaves on trigger (poll_req, period expiry, or pending flag).
- LATCH: `nes_latch` = 1 for 2 ticks.
- READ: bit index k = 0..7. Each bit: tick 1 with `nes_pulse` = 0, synchronized data sampled into shift buffer bit k on the edge ending tick 1; for k ≤ 6, tick 2 with `nes_pulse` = 1. Bit 7 has tick 1 only.
- DONE (1 cycle): `buttons*` ← buffers; `pressed*` ← new & ~old; `valid` = 1.
- `pressed*` hold their value until next DONE; only meaningful with `valid`.
- Period counter: runs when `enable` = 1, counts 0..POLL_PERIOD-1, expiry at POLL_PERIOD-1, wraps to 0; held at 0 when `enable` = 0.
- Trigger while busy (request or expiry): sets 1-deep `pending`; additional triggers coalesce. Pending is served from IDLE on the cycle after DONE and cleared on leaving IDLE.
- Simultaneous poll_req and expiry in IDLE: one poll, no pending.
- Trigger in the DONE cycle: sets pending.

## Timing
- Tick prescaler counts 0..CLK_DIV-1, tick = count==CLK_DIV-1; cleared on IDLE→LATCH so phases align.
- Let T0 = first cycle in LATCH. `nes_latch` high T0..T0+2D-1 (D = CLK_DIV).
- Bit k (k ≤ 6) pulse-low at T0+2D+2kD .. +D-1, pulse-high next D cycles. Bit 7 pulse-low T0+16D..T0+17D-1.
- DONE / `valid` at cycle T0+17D; outputs registered, visible following edge.
- Trigger-to-T0: 1 cycle from IDLE.
- Reset values: state IDLE, `nes_latch`/`nes_pulse`/`valid`/`busy` = 0, `buttons*`/`pressed*` = 0, counters 0, pending 0.
- Reset mid-poll: immediate return to IDLE, strobes low, partial buffer discarded, published vectors zeroed.

## Structure
- Package `nes_pkg`: FSM state enum typedef, button index constants BTN_A..BTN_RIGHT, NUM_PADS = 2.
- Sub-module `nes_tick_gen`: parameterised prescaler with sync clear and tick output.
- Top holds FSM, synchronizers, shift buffers, period counter, pending flag.

## Test plan
- CLK_DIV=4, pad0 holds A low, pad1 all high, poll_req at idle -> latch 8 cycles, 7 pulses of 4 cycles, valid at T0+68; buttons0=0x01, buttons1=0x00, pressed0=0x01.
- Second poll, same stimulus -> buttons0=0x01, pressed0=0x00; then release A, press Right -> buttons0=0x80, pressed0=0x80.
- enable=1, POLL_PERIOD=100, CLK_DIV=4 -> T0 every 100 cycles exactly; enable=0 -> no further latch.
- poll_req three times during READ -> exactly one extra poll, T0 two cycles after first valid.
- Reset asserted at bit 4 of a poll -> strobes low same cycle asynchronously, buttons*=0, no valid; next poll_req produces a correct full frame.
- poll_req and period expiry in same IDLE cycle -> single poll, busy drops after DONE, no back-to-back poll.
